cpu_ifetch: RTL and testbench

Instruction fetch unit sitting between the `cpu_pc` program counter and the Avalon-MM instruction memory port. It consumes the PC value and drives word-aligned Avalon reads, honouring `waitrequest`. It holds the fetched word until decode accepts it, then pulses the PC write-enable so the counter advances only after an instruction has been consumed. It also detects the architectural halt (fetch from address 0) and drops `active`.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/ifetch_byteswap.sv | 12 +
 rtl/cpu_ifetch.sv | 88 ++++++++
 tb/tb_cpu_ifetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and architectural addresses.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } ifetch_state_t;

  localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/ifetch_byteswap.sv
// Byte-reverses a fetched word so big-endian code can run over a little-endian bus.
// Only compiled when IFETCH_BYTESWAP_EN is defined; the default build has no use for it.
`ifdef IFETCH_BYTESWAP_EN
module ifetch_byteswap (
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  assign data_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};

endmodule
`endif

// File: rtl/cpu_ifetch.sv
// Instruction fetch: issues Avalon reads from the PC, holds the word for decode, gates PC advance.
// Define IFETCH_BYTESWAP_EN to byte-reverse captured words (big-endian code on a little-endian bus).
module cpu_ifetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_i,
  output logic              pc_wen_o,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic              active_o
);

  ifetch_state_t state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   rdata_cap;
  logic          at_halt;

  assign at_halt        = (pc_i == HALT_ADDR);
  assign avm_address    = ADDR_W'({pc_i[31:2], 2'b00});
  assign avm_byteenable = 4'b1111;
  assign instr_o        = instr_q;

`ifdef IFETCH_BYTESWAP_EN
  ifetch_byteswap u_byteswap (
    .data_i (avm_readdata),
    .data_o (rdata_cap)
  );
`else
  assign rdata_cap = avm_readdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    avm_read      = 1'b0;
    instr_valid_o = 1'b0;
    pc_wen_o      = 1'b0;
    active_o      = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        active_o = 1'b1;
        if (at_halt) begin
          state_d = S_HALT;
        end else begin
          avm_read = 1'b1;
          if (!avm_waitrequest) begin
            instr_d = rdata_cap;
            state_d = S_HOLD;
          end
        end
      end
      // PC advance is tied to the consume handshake so it never runs ahead of decode.
      S_HOLD: begin
        active_o      = 1'b1;
        instr_valid_o = 1'b1;
        if (instr_ready_i) begin
          pc_wen_o = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch with a transaction-level reference model and literal spot checks.
module tb_cpu_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        pc_wen_o;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        active_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_ifetch dut (
    .clk             (clk),
    .reset           (reset),
    .pc_i            (pc_i),
    .pc_wen_o        (pc_wen_o),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .instr_o         (instr_o),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .active_o        (active_o)
  );

  // Program image as the decoder should see it.
  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: memword = 32'h2402_0005;
      32'hBFC0_0004: memword = 32'h3C01_1234;
      32'hBFC0_0008: memword = 32'h8C22_0010;
      default:       memword = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] busword(input logic [31:0] a);
    logic [31:0] w;
    w = memword(a);
`ifdef IFETCH_BYTESWAP_EN
    busword = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    busword = w;
`endif
  endfunction

  assign avm_readdata = busword(avm_address);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: boot cycle, halted flag, and whether a word is waiting for decode.
  bit          chk_en   = 1'b0;
  bit          m_boot   = 1'b0;
  bit          m_halted = 1'b0;
  bit          m_have   = 1'b0;
  logic [31:0] m_word   = '0;

  always @(posedge clk) begin
    if (reset) begin
      chk_en   <= 1'b1;
      m_boot   <= 1'b1;
      m_halted <= 1'b0;
      m_have   <= 1'b0;
      m_word   <= '0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (!m_halted) begin
      if (!m_have) begin
        if (pc_i == 32'h0) m_halted <= 1'b1;
        else if (!avm_waitrequest) begin
          m_have <= 1'b1;
          m_word <= memword({pc_i[31:2], 2'b00});
        end
      end else if (instr_ready_i) begin
        m_have <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_act, e_vld, e_rd, e_wen;
      e_act = !m_boot && !m_halted;
      e_vld = e_act && m_have;
      e_rd  = e_act && !m_have && (pc_i != 32'h0);
      e_wen = e_vld && instr_ready_i;
      chk("m_active", 32'(active_o), 32'(e_act));
      chk("m_valid",  32'(instr_valid_o), 32'(e_vld));
      chk("m_read",   32'(avm_read), 32'(e_rd));
      chk("m_wen",    32'(pc_wen_o), 32'(e_wen));
      chk("m_instr",  instr_o, m_word);
      chk("m_be",     32'(avm_byteenable), 32'h0000_000F);
      if (e_rd) chk("m_addr", avm_address, {pc_i[31:2], 2'b00});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_i = 32'hBFC0_0000; avm_waitrequest = 1'b0; instr_ready_i = 1'b0;
    repeat (3) tick();
    #4;
    chk("rst_read",  32'(avm_read), 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_wen",   32'(pc_wen_o), 32'h0);
    chk("rst_active", 32'(active_o), 32'h0);
    tick();
    reset = 1'b0;
    #4; tick();
    #4;
    chk("boot_read", 32'(avm_read), 32'h1);
    chk("boot_addr", avm_address, 32'hBFC0_0000);
    tick();
    instr_ready_i = 1'b1;
    #4;
    chk("boot_instr",  instr_o, 32'h2402_0005);
    chk("boot_valid",  32'(instr_valid_o), 32'h1);
    chk("boot_active", 32'(active_o), 32'h1);
    chk("boot_wen",    32'(pc_wen_o), 32'h1);
    tick();
    pc_i = 32'hBFC0_0004;
    for (int i = 0; i < 3; i++) begin
      avm_waitrequest = 1'b1;
      #4;
      chk("stall_read", 32'(avm_read), 32'h1);
      chk("stall_addr", avm_address, 32'hBFC0_0004);
      chk("stall_wen",  32'(pc_wen_o), 32'h0);
      tick();
    end
    avm_waitrequest = 1'b0;
    #4;
    chk("stall_last_read", 32'(avm_read), 32'h1);
    chk("stall_instr_old", instr_o, 32'h2402_0005);
    tick();
    for (int i = 0; i < 5; i++) begin
      instr_ready_i = 1'b0;
      #4;
      chk("hold_instr", instr_o, 32'h3C01_1234);
      chk("hold_read",  32'(avm_read), 32'h0);
      chk("hold_wen",   32'(pc_wen_o), 32'h0);
      tick();
    end
    instr_ready_i = 1'b1;
    #4;
    chk("hold_accept_wen", 32'(pc_wen_o), 32'h1);
    tick();
    pc_i = 32'hBFC0_000B; instr_ready_i = 1'b0;
    #4;
    chk("unaligned_addr", avm_address, 32'hBFC0_0008);
    tick();
    instr_ready_i = 1'b1;
    #4;
    chk("unaligned_instr", instr_o, 32'h8C22_0010);
    tick();
    pc_i = 32'h0; instr_ready_i = 1'b0;
    #4;
    chk("halt_noread", 32'(avm_read), 32'h0);
    chk("halt_active_last", 32'(active_o), 32'h1);
    tick();
    for (int i = 0; i < 10; i++) begin
      #4;
      chk("halted_active", 32'(active_o), 32'h0);
      chk("halted_read",   32'(avm_read), 32'h0);
      tick();
    end
    reset = 1'b1; pc_i = 32'hBFC0_0000;
    #4; tick();
    reset = 1'b0; avm_waitrequest = 1'b1;
    #4; tick();
    #4;
    chk("rst2_stall_read", 32'(avm_read), 32'h1);
    tick();
    reset = 1'b1;
    #4;
    chk("rst2_stall_read2", 32'(avm_read), 32'h1);
    tick();
    reset = 1'b0; avm_waitrequest = 1'b0;
    #4;
    chk("midrst_read",  32'(avm_read), 32'h0);
    chk("midrst_valid", 32'(instr_valid_o), 32'h0);
    chk("midrst_instr", instr_o, 32'h0);
    tick();
    #4;
    chk("refetch_read", 32'(avm_read), 32'h1);
    chk("refetch_addr", avm_address, 32'hBFC0_0000);
    tick();
    instr_ready_i = 1'b1;
    #4;
    chk("refetch_instr", instr_o, 32'h2402_0005);
    chk("refetch_valid", 32'(instr_valid_o), 32'h1);
    tick();
    pc_i = 32'hBFC0_0004; instr_ready_i = 1'b0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
